// File: rtl/alu_core_pkg.sv
// Shared types and width for the ALU core.
package CPU_package;

    localparam int unsigned DATA_WIDTH = 16;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpMul = 4'd2,
        OpDiv = 4'd3,
        OpShl = 4'd4,
        OpShr = 4'd5,
        OpAnd = 4'd6,
        OpOr  = 4'd7,
        OpXor = 4'd8,
        OpNot = 4'd9,
        OpCpr = 4'd10
    } enum_alu_opcode_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic sign;
        logic overflow;
        logic equal;
        logic greater;
        logic error;
    } struct_alu_flag_t;

endpackage

// File: rtl/alu_core_if.sv
// Operand/opcode/result bundle between an ALU client (master) and the ALU (slave).
interface alu_core_if
    import CPU_package::*;
#(
    parameter int unsigned DATA_WIDTH = CPU_package::DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic                  input_carry;
    enum_alu_opcode_t      alu_opcode;
    logic                  alu_mode;
    logic [DATA_WIDTH-1:0] alu_out;
    struct_alu_flag_t      alu_out_flag;

    modport master (
        output in_a, in_b, input_carry, alu_opcode, alu_mode,
        input  alu_out, alu_out_flag
    );

    modport slave (
        input  in_a, in_b, input_carry, alu_opcode, alu_mode,
        output alu_out, alu_out_flag
    );
endinterface

// File: rtl/alu_comb.sv
// Combinational ALU datapath: result and flags for one operation.
// MUL/DIV hardware exists only when ALU_MULDIV_EN is defined.
module alu_comb
    import CPU_package::*;
#(
    parameter int unsigned DATA_WIDTH = CPU_package::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_carry,
    input  enum_alu_opcode_t      i_opcode,
    input  logic                  i_mode,
    output logic [DATA_WIDTH-1:0] o_result,
    output struct_alu_flag_t      o_flag
);
    localparam int unsigned W = DATA_WIDTH;

    logic [W:0]   w_sum;
    logic [W:0]   w_diff;
    logic [W-1:0] w_result;
    logic         w_legal;
    struct_alu_flag_t w_flag;

    // Bit W of the widened difference is the borrow out.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_carry};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {{W{1'b0}}, i_carry};

`ifdef ALU_MULDIV_EN
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quot;
    assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
    assign w_quot = (i_b == '0) ? '1 : i_a / i_b;
`endif

    always_comb begin
        w_result = '0;
        w_flag   = '0;
        w_legal  = 1'b1;
        case (i_opcode)
            OpAdd: begin
                w_result      = w_sum[W-1:0];
                w_flag.carry  = w_sum[W];
                w_flag.overflow = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);
            end
            OpSub: begin
                w_result      = w_diff[W-1:0];
                w_flag.carry  = w_diff[W];
                w_flag.overflow = (i_a[W-1] != i_b[W-1]) && (w_diff[W-1] != i_a[W-1]);
            end
`ifdef ALU_MULDIV_EN
            OpMul: begin
                w_result        = w_prod[W-1:0];
                w_flag.overflow = |w_prod[2*W-1:W];
            end
            OpDiv: begin
                w_result     = w_quot;
                w_flag.error = (i_b == '0);
            end
`endif
            OpShl: begin
                w_result     = {i_a[W-2:0], 1'b0};
                w_flag.carry = i_a[W-1];
            end
            OpShr: begin
                w_result     = {1'b0, i_a[W-1:1]};
                w_flag.carry = i_a[0];
            end
            OpAnd: w_result = i_a & i_b;
            OpOr:  w_result = i_a | i_b;
            OpXor: w_result = i_a ^ i_b;
            OpNot: w_result = ~i_a;
            OpCpr: begin
                w_flag.equal   = (i_a == i_b);
                w_flag.greater = (i_a > i_b);
                if (i_a > i_b) begin
                    w_result = W'(1);
                end else if (i_a < i_b) begin
                    w_result = W'(2);
                end
            end
            default: w_legal = 1'b0;
        endcase

        if (w_legal) begin
            w_flag.zero = (w_result == '0);
            w_flag.sign = w_result[W-1];
            if (i_mode) begin
                w_flag.carry    = 1'b0;
                w_flag.overflow = 1'b0;
            end
        end else begin
            w_result     = '0;
            w_flag       = '0;
            w_flag.error = 1'b1;
        end
    end

    assign o_result = w_result;
    assign o_flag   = w_flag;
endmodule

// File: rtl/alu_core.sv
// Registered ALU: one result and flag set per cycle, cleared asynchronously by rst_n.
// Optional MUL/DIV support via the ALU_MULDIV_EN macro.
module alu_core
    import CPU_package::*;
#(
    parameter int unsigned DATA_WIDTH = CPU_package::DATA_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_core_if.slave  bus
);
    logic [DATA_WIDTH-1:0] w_result;
    struct_alu_flag_t      w_flag;
    logic [DATA_WIDTH-1:0] r_out;
    struct_alu_flag_t      r_flag;

    alu_comb #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu_comb (
        .i_a      (bus.in_a),
        .i_b      (bus.in_b),
        .i_carry  (bus.input_carry),
        .i_opcode (bus.alu_opcode),
        .i_mode   (bus.alu_mode),
        .o_result (w_result),
        .o_flag   (w_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_flag <= '0;
        end else begin
            r_out  <= w_result;
            r_flag <= w_flag;
        end
    end

    assign bus.alu_out      = r_out;
    assign bus.alu_out_flag = r_flag;
endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: directed vectors, expected results queued at issue time.
module tb_alu_core;
    import CPU_package::*;

    logic clk;
    logic rst_n;

    alu_core_if bus ();

    alu_core u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0]      exp_out_q[$];
    struct_alu_flag_t exp_flag_q[$];
    string            exp_name_q[$];
    int checks;
    int errors;

    function automatic struct_alu_flag_t fl(input logic c, z, s, o, e, g, er);
        struct_alu_flag_t f;
        f.carry = c; f.zero = z; f.sign = s; f.overflow = o;
        f.equal = e; f.greater = g; f.error = er;
        return f;
    endfunction

    task automatic check(input string nm, input logic [15:0] exp_o, input struct_alu_flag_t exp_f);
        checks++;
        if (bus.alu_out !== exp_o || bus.alu_out_flag !== exp_f) begin
            errors++;
            $display("FAIL %s: got out=%h flags=%b, expected out=%h flags=%b",
                     nm, bus.alu_out, bus.alu_out_flag, exp_o, exp_f);
        end
    endtask

    task automatic monitor();
        forever begin
            @(posedge clk);
            #1;
            if (exp_out_q.size() != 0) begin
                check(exp_name_q.pop_front(), exp_out_q.pop_front(), exp_flag_q.pop_front());
            end
        end
    endtask

    task automatic drive(input enum_alu_opcode_t op, input logic [15:0] a, b,
                         input logic cin, mode);
        bus.alu_opcode  = op;
        bus.in_a        = a;
        bus.in_b        = b;
        bus.input_carry = cin;
        bus.alu_mode    = mode;
    endtask

    task automatic issue(input string nm, input enum_alu_opcode_t op, input logic [15:0] a, b,
                         input logic cin, mode, input logic [15:0] eo,
                         input struct_alu_flag_t ef);
        @(negedge clk);
        drive(op, a, b, cin, mode);
        exp_out_q.push_back(eo);
        exp_flag_q.push_back(ef);
        exp_name_q.push_back(nm);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(OpAdd, 16'd7, 16'd8, 1'b0, 1'b0);
        fork
            monitor();
        join_none
        #3;
        check("reset_state", 16'h0000, fl(0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", 16'h0000, fl(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        issue("add_7_8",      OpAdd, 16'd7,    16'd8, 0, 0, 16'd15,   fl(0, 0, 0, 0, 0, 0, 0));
        issue("add_wrap",     OpAdd, 16'hFFFF, 16'd1, 0, 0, 16'h0000, fl(1, 1, 0, 0, 0, 0, 0));
        issue("add_ovf",      OpAdd, 16'h7FFF, 16'd1, 0, 0, 16'h8000, fl(0, 0, 1, 1, 0, 0, 0));
        issue("add_cin",      OpAdd, 16'd5,    16'd5, 1, 0, 16'd11,   fl(0, 0, 0, 0, 0, 0, 0));
        issue("sub_5_3",      OpSub, 16'd5,    16'd3, 0, 0, 16'd2,    fl(0, 0, 0, 0, 0, 0, 0));
        issue("sub_borrow",   OpSub, 16'd3,    16'd5, 0, 0, 16'hFFFE, fl(1, 0, 1, 0, 0, 0, 0));
        issue("sub_ovf",      OpSub, 16'h8000, 16'd1, 0, 0, 16'h7FFF, fl(0, 0, 0, 1, 0, 0, 0));
        issue("sub_bin",      OpSub, 16'd5,    16'd5, 1, 0, 16'hFFFF, fl(1, 0, 1, 0, 0, 0, 0));
        issue("add_mode1",    OpAdd, 16'hFFFF, 16'd1, 0, 1, 16'h0000, fl(0, 1, 0, 0, 0, 0, 0));
        issue("cpr_eq",       OpCpr, 16'd2,    16'd2, 0, 1, 16'd0,    fl(0, 1, 0, 0, 1, 0, 0));
        issue("cpr_gt",       OpCpr, 16'd20,   16'd10, 0, 1, 16'd1,   fl(0, 0, 0, 0, 0, 1, 0));
        issue("cpr_lt",       OpCpr, 16'd2,    16'd10, 0, 1, 16'd2,   fl(0, 0, 0, 0, 0, 0, 0));
        issue("shr_4",        OpShr, 16'd4,    16'hFFFF, 0, 0, 16'd2, fl(0, 0, 0, 0, 0, 0, 0));
        issue("shl_4",        OpShl, 16'd4,    16'hFFFF, 0, 0, 16'd8, fl(0, 0, 0, 0, 0, 0, 0));
        issue("shl_carry",    OpShl, 16'h8001, 16'd0, 0, 0, 16'h0002, fl(1, 0, 0, 0, 0, 0, 0));
        issue("shr_carry",    OpShr, 16'h0003, 16'd0, 0, 0, 16'h0001, fl(1, 0, 0, 0, 0, 0, 0));
        issue("shl_mode1",    OpShl, 16'h8001, 16'd0, 0, 1, 16'h0002, fl(0, 0, 0, 0, 0, 0, 0));
        issue("and_1_0",      OpAnd, 16'd1,    16'd0, 0, 0, 16'd0,    fl(0, 1, 0, 0, 0, 0, 0));
        issue("or_1_0",       OpOr,  16'd1,    16'd0, 0, 0, 16'd1,    fl(0, 0, 0, 0, 0, 0, 0));
        issue("xor",          OpXor, 16'hF0F0, 16'hFF00, 0, 0, 16'h0FF0, fl(0, 0, 0, 0, 0, 0, 0));
        issue("not_0",        OpNot, 16'h0000, 16'h1234, 0, 0, 16'hFFFF, fl(0, 0, 1, 0, 0, 0, 0));
        issue("illegal_11",   enum_alu_opcode_t'(4'd11), 16'd3, 16'd4, 0, 0, 16'd0,
              fl(0, 0, 0, 0, 0, 0, 1));
        issue("illegal_15",   enum_alu_opcode_t'(4'd15), 16'hFFFF, 16'd1, 1, 0, 16'd0,
              fl(0, 0, 0, 0, 0, 0, 1));
`ifdef ALU_MULDIV_EN
        issue("mul_2_2",      OpMul, 16'd2,    16'd2, 0, 0, 16'd4,    fl(0, 0, 0, 0, 0, 0, 0));
        issue("mul_ovf",      OpMul, 16'h0100, 16'h0100, 0, 0, 16'd0, fl(0, 1, 0, 1, 0, 0, 0));
        issue("div_10_2",     OpDiv, 16'd10,   16'd2, 0, 0, 16'd5,    fl(0, 0, 0, 0, 0, 0, 0));
        issue("div_7_2",      OpDiv, 16'd7,    16'd2, 0, 0, 16'd3,    fl(0, 0, 0, 0, 0, 0, 0));
        issue("div_by_0",     OpDiv, 16'd10,   16'd0, 0, 0, 16'hFFFF, fl(0, 0, 1, 0, 0, 0, 1));
`else
        issue("mul_disabled", OpMul, 16'd2,    16'd2, 0, 0, 16'd0,    fl(0, 0, 0, 0, 0, 0, 1));
        issue("div_disabled", OpDiv, 16'd10,   16'd2, 0, 0, 16'd0,    fl(0, 0, 0, 0, 0, 0, 1));
`endif
        issue("add_pre_rst",  OpAdd, 16'd7,    16'd8, 0, 0, 16'd15,   fl(0, 0, 0, 0, 0, 0, 0));

        // Reset asserted between edges with a new operation pending.
        @(negedge clk);
        drive(OpAdd, 16'd1, 16'd1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_clear", 16'h0000, fl(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("rst_discard", 16'h0000, fl(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_hold", 16'h0000, fl(0, 0, 0, 0, 0, 0, 0));
        exp_out_q.push_back(16'd2);
        exp_flag_q.push_back(fl(0, 0, 0, 0, 0, 0, 0));
        exp_name_q.push_back("first_after_rst");

        repeat (4) @(posedge clk);
        #2;
        if (exp_out_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results, expected 0", exp_out_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
